// File: rtl/tt_um_count_checker.sv
// Receive-side checker for the 8-bit counter stream: locks on +1 steps, then counts sequence breaks.
// Optional `COUNT_CHECK_DOWN_EN: uio_in[3] (dir)=1 expects -1 steps instead of +1.
module tt_um_count_checker #(
    parameter int unsigned LOCK_COUNT = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam int unsigned DATA_W = 8;

    localparam logic [1:0] ST_HUNT   = 2'd0;
    localparam logic [1:0] ST_ACQ    = 2'd1;
    localparam logic [1:0] ST_LOCKED = 2'd2;

    localparam logic [3:0]        LOCK_TARGET = 4'(LOCK_COUNT);
    localparam logic [DATA_W-1:0] CNT_MAX     = '1;

    logic              sample_en;
    logic              clr;
    logic              sel;
    logic              dir;

    logic [1:0]        state_q, state_d;
    logic [DATA_W-1:0] prev_q, prev_d;
    logic [3:0]        good_q, good_d;
    logic [DATA_W-1:0] err_cnt_q, err_cnt_d;
    logic              err_sat_q, err_sat_d;
    logic              err_pulse_q, err_pulse_d;

    logic [DATA_W-1:0] exp_val;
    logic              hit;
    logic              err_hit;
    logic [3:0]        good_inc;

    assign sample_en = uio_in[0];
    assign clr       = uio_in[1];
    assign sel       = uio_in[2];
    assign dir       = uio_in[3];

`ifdef COUNT_CHECK_DOWN_EN
    assign exp_val = dir ? (prev_q - DATA_W'(1)) : (prev_q + DATA_W'(1));
`else
    assign exp_val = prev_q + DATA_W'(1);
`endif

    // ena, the spare uio inputs and (in the default build) dir have no function.
    logic unused_ok;
    assign unused_ok = &{1'b0, ena, uio_in[7:4], dir};

    assign hit      = (ui_in == exp_val);
    assign good_inc = good_q + 4'd1;

    always_comb begin
        state_d = state_q;
        prev_d  = prev_q;
        good_d  = good_q;
        err_hit = 1'b0;

        if (sample_en) begin
            prev_d = ui_in;
            case (state_q)
                ST_HUNT: begin
                    state_d = ST_ACQ;
                    good_d  = 4'd0;
                end
                ST_ACQ: begin
                    if (hit) begin
                        good_d = good_inc;
                        if (good_inc == LOCK_TARGET) begin
                            state_d = ST_LOCKED;
                        end
                    end else begin
                        good_d = 4'd0;
                    end
                end
                ST_LOCKED: begin
                    if (!hit) begin
                        err_hit = 1'b1;
                        state_d = ST_ACQ;
                        good_d  = 4'd0;
                    end
                end
                default: begin
                    state_d = ST_HUNT;
                    good_d  = 4'd0;
                end
            endcase
        end
    end

    // Clear is applied first so an error in the same cycle still lands as a count of one.
    always_comb begin
        err_cnt_d   = err_cnt_q;
        err_sat_d   = err_sat_q;
        err_pulse_d = err_hit;

        if (clr) begin
            err_cnt_d = '0;
            err_sat_d = 1'b0;
        end
        if (err_hit && (err_cnt_d != CNT_MAX)) begin
            err_cnt_d = err_cnt_d + DATA_W'(1);
        end
        if (err_cnt_d == CNT_MAX) begin
            err_sat_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_HUNT;
            prev_q      <= '0;
            good_q      <= 4'd0;
            err_cnt_q   <= '0;
            err_sat_q   <= 1'b0;
            err_pulse_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            prev_q      <= prev_d;
            good_q      <= good_d;
            err_cnt_q   <= err_cnt_d;
            err_sat_q   <= err_sat_d;
            err_pulse_q <= err_pulse_d;
        end
    end

    assign uo_out  = sel ? prev_q : err_cnt_q;
    assign uio_out = {(state_q == ST_ACQ), err_sat_q, err_pulse_q, (state_q == ST_LOCKED), 4'b0000};
    assign uio_oe  = 8'hF0;

endmodule

// File: tb/tb_tt_um_count_checker.sv
// Directed bench for tt_um_count_checker with LOCK_COUNT = 4 and hand-computed expectations.
module tb_tt_um_count_checker;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b1;
    logic [7:0] ui_in = 8'd0;
    logic       sample_en = 1'b0;
    logic       clr = 1'b0;
    logic       sel = 1'b0;
    logic       dir = 1'b0;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int n_cmp = 0;
    int n_err = 0;
    logic [7:0] p;
    logic [7:0] v;

    assign uio_in = {4'b0000, dir, sel, clr, sample_en};

    tt_um_count_checker #(.LOCK_COUNT(4)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .ena    (ena),
        .ui_in  (ui_in),
        .uio_in (uio_in),
        .uo_out (uo_out),
        .uio_out(uio_out),
        .uio_oe (uio_oe)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
        n_cmp++;
        if (got !== expv) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, expv);
        end
    endtask

    task automatic sample(input logic [7:0] val);
        ui_in     = val;
        sample_en = 1'b1;
        @(posedge clk);
        #1;
        sample_en = 1'b0;
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
    endtask

    // Four consecutive +1 steps from the current p.
    task automatic relock();
        for (int k = 0; k < 4; k++) begin
            p = p + 8'd1;
            sample(p);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        idle();
        idle();
        check("rst_uo", uo_out, 8'h00);
        check("rst_uio", uio_out, 8'h00);
        check("rst_oe", uio_oe, 8'hF0);
        rst_n = 1'b1;

        sample(8'd0);
        check("acq_first", uio_out[7], 1'b1);
        check("lock_first", uio_out[4], 1'b0);
        sample(8'd1);
        sample(8'd2);
        sample(8'd3);
        check("lock_3", uio_out[4], 1'b0);
        sample(8'd4);
        check("lock_4", uio_out[4], 1'b1);
        check("acq_4", uio_out[7], 1'b0);
        check("cnt_4", uo_out, 8'd0);

        for (int i = 5; i <= 252; i++) sample(8'(i));
        v = 8'd253;
        for (int i = 0; i < 5; i++) begin
            sample(v);
            check("wrap_lock", uio_out[4], 1'b1);
            check("wrap_pulse", uio_out[5], 1'b0);
            v = v + 8'd1;
        end

        sample(8'd10);
        check("err10_pulse", uio_out[5], 1'b1);
        check("err10_cnt", uo_out, 8'd1);
        check("err10_acq", uio_out[7], 1'b1);
        sample(8'd12);
        check("err12_pulse", uio_out[5], 1'b0);
        check("err12_cnt", uo_out, 8'd1);
        sample(8'd13);
        sample(8'd14);
        sample(8'd15);
        check("relock_15", uio_out[4], 1'b0);
        sample(8'd16);
        check("relock_16", uio_out[4], 1'b1);
        check("relock_cnt", uo_out, 8'd1);

        sel = 1'b1;
        #1;
        check("sel_prev", uo_out, 8'd16);
        ui_in = 8'd99;
        idle();
        check("hold_prev", uo_out, 8'd16);
        check("hold_lock", uio_out[4], 1'b1);
        sel = 1'b0;
        #1;
        check("sel_cnt", uo_out, 8'd1);

        clr = 1'b1;
        idle();
        clr = 1'b0;
        check("clr_cnt", uo_out, 8'd0);
        check("clr_lock", uio_out[4], 1'b1);

        p = 8'd16;
        for (int i = 1; i <= 255; i++) begin
            v = p + 8'd2;
            sample(v);
            check("sat_pulse", uio_out[5], 1'b1);
            if (i == 254) begin
                check("cnt_254", uo_out, 8'd254);
                check("sat_254", uio_out[6], 1'b0);
            end
            if (i == 255) begin
                check("cnt_255", uo_out, 8'd255);
                check("sat_255", uio_out[6], 1'b1);
            end
            p = v;
            relock();
        end
        check("sat_relock", uio_out[4], 1'b1);
        v = p + 8'd2;
        sample(v);
        p = v;
        check("err256_pulse", uio_out[5], 1'b1);
        check("err256_cnt", uo_out, 8'd255);
        check("err256_sat", uio_out[6], 1'b1);
        idle();
        check("pulse_one_cycle", uio_out[5], 1'b0);
        clr = 1'b1;
        idle();
        clr = 1'b0;
        check("clr_sat_cnt", uo_out, 8'd0);
        check("clr_sat_flag", uio_out[6], 1'b0);

        relock();
        check("lock_a", uio_out[4], 1'b1);
        p = p + 8'd2;
        sample(p);
        check("err_a_cnt", uo_out, 8'd1);
        relock();
        check("lock_b", uio_out[4], 1'b1);
        p = p + 8'd2;
        clr = 1'b1;
        sample(p);
        clr = 1'b0;
        check("clr_err_cnt", uo_out, 8'd1);
        check("clr_err_pulse", uio_out[5], 1'b1);
        check("clr_err_sat", uio_out[6], 1'b0);

        relock();
        check("lock_c", uio_out[4], 1'b1);
        rst_n     = 1'b0;
        ui_in     = 8'd77;
        sample_en = 1'b1;
        idle();
        sample_en = 1'b0;
        check("rst_lock_uio", uio_out, 8'h00);
        check("rst_lock_cnt", uo_out, 8'h00);
        sel = 1'b1;
        #1;
        check("rst_lock_prev", uo_out, 8'h00);
        sel = 1'b0;
        rst_n = 1'b1;
        sample(8'd50);
        check("rst_hunt_acq", uio_out[7], 1'b1);

`ifdef COUNT_CHECK_DOWN_EN
        rst_n = 1'b0;
        idle();
        rst_n = 1'b1;
        dir = 1'b1;
        sample(8'd2);
        sample(8'd1);
        sample(8'd0);
        sample(8'd255);
        sample(8'd254);
        check("down_lock", uio_out[4], 1'b1);
        check("down_cnt", uo_out, 8'd0);
        dir = 1'b0;
        sample(8'd253);
        check("dir_flip_pulse", uio_out[5], 1'b1);
        check("dir_flip_cnt", uo_out, 8'd1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/tt_um_count_checker.md
# tt_um_count_checker

Receive-side checker for the 8-bit free-running count stream produced by the team's counter tile. It samples an 8-bit value on `ui_in`, locks once consecutive samples step by exactly one, and then counts every break in the sequence. It sits at the far end of a chip-to-chip or loopback link as a bring-up and link-integrity monitor. Status is reported on `uio_out`, and the error count or last sample on `uo_out`.

## Interface
Parameters:
- `LOCK_COUNT`, default 4: consecutive good steps required to lock; legal range 1..15.

Ports:
- `clk`  in  1  clock
- `rst_n`  in  1  reset, synchronous, active-low
- `ena`  in  1  power-good; ignored
- `ui_in`  in  8  sample data (the counter value)
- `uio_in[0]` `sample_en`  in  1  sample valid; data is checked only when high
- `uio_in[1]` `clr`  in  1  synchronous clear of the error count and saturation flag
- `uio_in[2]` `sel`  in  1  `uo_out` source: 0 = error count, 1 = last sample
- `uio_in[3]` `dir`  in  1  expected direction; only used with `COUNT_CHECK_DOWN_EN`
- `uio_in[7:4]`  unused
- `uo_out`  out  8  error count or last sample, per `sel`
- `uio_out[4]` `locked`  out  1  state is LOCKED
- `uio_out[5]` `err_pulse`  out  1  one-cycle pulse per counted error
- `uio_out[6]` `err_sat`  out  1  sticky flag: error count reached 255
- `uio_out[7]` `acq`  out  1  state is ACQ
- `uio_out[3:0]`  tied to 0
- `uio_oe`  out  8  constant `8'hF0`

## Operation
Internal registers:
- `prev[7:0]`: last sample
- `good_cnt[3:0]`: consecutive good steps
- `err_cnt[7:0]`: errors, saturating at 255
- `state`: HUNT / ACQ / LOCKED

Definitions:
- Expected value: `exp = prev + 1` modulo 256. 255 -> 0 is a good step.
- A sample is taken at a rising edge with `sample_en`=1. With `sample_en`=0, all state is held; only `clr` acts.
- Every taken sample is written to `prev`.

State machine:
- HUNT: on a sample -> ACQ, with `good_cnt` = 0.
- ACQ, sample == `exp`: `good_cnt`+1. If the new value equals `LOCK_COUNT` -> LOCKED.
- ACQ, sample != `exp`: `good_cnt` = 0, stay in ACQ. No error is counted.
- LOCKED, sample == `exp`: stay in LOCKED.
- LOCKED, sample != `exp`:
  - `err_pulse` fires.
  - `err_cnt` = min(`err_cnt`+1, 255); `err_sat` is set when the count reaches 255.
  - Go to ACQ with `good_cnt` = 0.
  - The mismatching sample becomes the new `prev`.

Error count and clear:
- At saturation (`err_cnt` = 255), further errors still pulse `err_pulse` but leave the count unchanged.
- `clr` zeroes `err_cnt` and `err_sat`. It does not affect `state`, `prev` or `good_cnt`.
- `clr` and a counted error in the same cycle: `err_cnt` = 1 and `err_sat` = 0 (the error is not lost).

Reset:
- `rst_n`=0 at an edge forces `state`=HUNT and `prev`, `good_cnt`, `err_cnt`, `err_sat`, `err_pulse` = 0, regardless of the other inputs.
- So `uo_out` = 0, `uio_out` = 0, `uio_oe` = `8'hF0` from the edge after reset.

## Timing
- All outputs are registered. A sample taken at edge N is reflected from edge N on, i.e. visible in the cycle after edge N.
- `locked` rises the cycle after the edge that takes the `LOCK_COUNT`-th good step. Minimum from the first sample is `LOCK_COUNT`+1 sampled edges.
- `err_pulse` is high for exactly one cycle after each erroring edge.
- Back-to-back mismatches: only the first one counts, because the machine is then in ACQ.
- `uo_out` with `sel`=1 shows `prev`. `sel` is a combinational mux of registered values, so a change of `sel` shows on `uo_out` in the same cycle.

## Configuration
- `COUNT_CHECK_DOWN_EN` defined: `dir`=1 selects `exp = prev - 1` modulo 256, so 0 -> 255 is a good step. `dir`=0 keeps +1. A change of `dir` while LOCKED produces an ordinary mismatch and error.
- Not defined: `dir` is ignored and `exp` is always `prev + 1`.

## Test plan
- Reset, then `sample_en`=1 with `ui_in` = 0,1,2,3,4, `LOCK_COUNT`=4 -> `acq`=1 after the first sample; `locked`=1 after the sample value 4; `err_cnt`=0.
- While locked, feed 253,254,255,0,1 -> `locked` stays 1, no `err_pulse`.
- While locked, feed 10 then 12 -> one `err_pulse`; `err_cnt`=1; `acq`=1. Then 13,14,15,16 -> relocked; `err_cnt` still 1.
- Force 256 lock/break cycles -> `err_cnt`=255 and `err_sat`=1 after the 255th error; the 256th error pulses but the count stays 255. Then `clr` -> `uo_out`=0 (`sel`=0), `err_sat`=0.
- `clr` in the same cycle as an error -> `err_cnt`=1. `rst_n`=0 while locked with `sample_en`=1 -> all outputs 0, state HUNT.
- With `COUNT_CHECK_DOWN_EN` and `dir`=1, feed 2,1,0,255,254 -> locked, no errors. Flip `dir` to 0 and feed 253 -> one error.
